// File: rtl/dac_soft_mute_gain.sv
// Stereo gain stage: one ramped gain shared by L/R, stepped once per frame toward a
// volume/mute target, so enable, mute and volume changes never step the output.
module dac_soft_mute_gain #(
   parameter int unsigned DATA_W    = 24,
   parameter int unsigned GAIN_FRAC = 8,
   parameter int unsigned RAMP_STEP = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   input  logic              mute_req,
   input  logic [7:0]        volume,
   input  logic              l_data_en,
   input  logic              r_data_en,
   input  logic [DATA_W-1:0] l_data_in,
   input  logic [DATA_W-1:0] r_data_in,
   output logic              l_data_valid,
   output logic              r_data_valid,
   output logic [DATA_W-1:0] l_data_out,
   output logic [DATA_W-1:0] r_data_out,
   output logic              muted,
   output logic              ramping
);

   localparam int unsigned GainW = GAIN_FRAC + 1;
   localparam int unsigned ProdW = DATA_W + GAIN_FRAC + 2;
   localparam logic [GainW-1:0] Unity = GainW'(1 << GAIN_FRAC);
   localparam logic [GainW-1:0] Step  = GainW'(RAMP_STEP);

   localparam logic [1:0] StOff  = 2'd0;
   localparam logic [1:0] StRamp = 2'd1;
   localparam logic [1:0] StHold = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [GainW-1:0] gain_q, gain_d;
   logic [GainW-1:0] tgt;
   logic [GainW-1:0] gain_step;
   logic             muted_q;

   logic [ProdW-1:0] l_prod, r_prod;
   logic [ProdW-1:0] l_prod_q, r_prod_q;
   logic [ProdW-1:0] gain_ext;
   logic             l_v1_q, r_v1_q;
   logic             l_valid_q, r_valid_q;
   logic [DATA_W-1:0] l_out_q, r_out_q;
   logic             prod_unused;

   always_comb begin
      tgt = '0;
      if (!mute_req) begin
         tgt = (volume == 8'hFF) ? Unity : GainW'(volume);
      end
   end

   // Step toward the target, clamping the last step so the gain never overshoots.
   always_comb begin
      gain_step = gain_q;
      if (tgt > gain_q) begin
         gain_step = ((tgt - gain_q) < Step) ? tgt : gain_q + Step;
      end else if (tgt < gain_q) begin
         gain_step = ((gain_q - tgt) < Step) ? tgt : gain_q - Step;
      end
   end

   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      if (!run) begin
         state_d = StOff;
         gain_d  = '0;
      end else begin
         case (state_q)
            StOff: state_d = StRamp;
            StRamp, StHold: begin
               if (r_data_en) begin
                  gain_d  = gain_step;
                  state_d = (gain_step == tgt) ? StHold : StRamp;
               end else if (state_q == StHold && tgt != gain_q) begin
                  state_d = StRamp;
               end
            end
            default: state_d = StOff;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StOff;
         gain_q  <= '0;
         muted_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gain_q  <= gain_d;
         muted_q <= mute_req && (gain_q == '0);
      end
   end

   // Sign-extend the sample, zero-extend the gain; the low ProdW bits of the product are exact.
   assign gain_ext = {{(ProdW-GainW){1'b0}}, gain_q};
   assign l_prod   = {{(ProdW-DATA_W){l_data_in[DATA_W-1]}}, l_data_in} * gain_ext;
   assign r_prod   = {{(ProdW-DATA_W){r_data_in[DATA_W-1]}}, r_data_in} * gain_ext;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         l_prod_q  <= '0;
         r_prod_q  <= '0;
         l_v1_q    <= 1'b0;
         r_v1_q    <= 1'b0;
         l_valid_q <= 1'b0;
         r_valid_q <= 1'b0;
         l_out_q   <= '0;
         r_out_q   <= '0;
      end else if (!run) begin
         l_prod_q  <= '0;
         r_prod_q  <= '0;
         l_v1_q    <= 1'b0;
         r_v1_q    <= 1'b0;
         l_valid_q <= 1'b0;
         r_valid_q <= 1'b0;
         l_out_q   <= '0;
         r_out_q   <= '0;
      end else begin
         l_v1_q    <= l_data_en;
         r_v1_q    <= r_data_en;
         l_valid_q <= l_v1_q;
         r_valid_q <= r_v1_q;
         if (l_data_en) l_prod_q <= l_prod;
         if (r_data_en) r_prod_q <= r_prod;
         if (l_v1_q) l_out_q <= l_prod_q[DATA_W+GAIN_FRAC-1:GAIN_FRAC];
         if (r_v1_q) r_out_q <= r_prod_q[DATA_W+GAIN_FRAC-1:GAIN_FRAC];
      end
   end

   assign prod_unused = ^{l_prod_q[ProdW-1:DATA_W+GAIN_FRAC], l_prod_q[GAIN_FRAC-1:0],
                          r_prod_q[ProdW-1:DATA_W+GAIN_FRAC], r_prod_q[GAIN_FRAC-1:0]};

   assign l_data_valid = l_valid_q;
   assign r_data_valid = r_valid_q;
   assign l_data_out   = l_out_q;
   assign r_data_out   = r_out_q;
   assign muted        = muted_q;
   assign ramping      = (state_q == StRamp);

endmodule

// File: tb/tb_dac_soft_mute_gain.sv
// Bench for dac_soft_mute_gain: reference gain model plus per-channel scoreboard
// queues checked at negedge, with constant vector tables at fixed gains.
module tb_dac_soft_mute_gain;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        run = 1'b0;
   logic        mute_req = 1'b0;
   logic [7:0]  volume = 8'hFF;
   logic        l_data_en = 1'b0;
   logic        r_data_en = 1'b0;
   logic [23:0] l_data_in = '0;
   logic [23:0] r_data_in = '0;
   logic        l_data_valid, r_data_valid;
   logic [23:0] l_data_out, r_data_out;
   logic        muted, ramping;

   dac_soft_mute_gain dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .run          (run),
      .mute_req     (mute_req),
      .volume       (volume),
      .l_data_en    (l_data_en),
      .r_data_en    (r_data_en),
      .l_data_in    (l_data_in),
      .r_data_in    (r_data_in),
      .l_data_valid (l_data_valid),
      .r_data_valid (r_data_valid),
      .l_data_out   (l_data_out),
      .r_data_out   (r_data_out),
      .muted        (muted),
      .ramping      (ramping)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] data;
      int          due;
   } exp_t;

   typedef struct {
      logic [23:0] l_in;
      logic [23:0] r_in;
      logic [23:0] exp_l;
      logic [23:0] exp_r;
   } vec_t;

   exp_t lq[$];
   exp_t rq[$];
   vec_t unity_tbl[4];
   vec_t g64_tbl[4];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   g_m = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_tgt();
      if (mute_req) return 0;
      return (volume == 8'hFF) ? 256 : int'(volume);
   endfunction

   function automatic logic [23:0] scale(input logic [23:0] d, input int g);
      longint p;
      p = longint'($signed(d)) * longint'(g);
      p = p >>> 8;
      return p[23:0];
   endfunction

   task automatic model_step();
      int t;
      t = model_tgt();
      if (t > g_m) g_m = g_m + 1;
      else if (t < g_m) g_m = g_m - 1;
   endtask

   // mode 0: L and R on the same clk; mode 1: L then R on consecutive clks.
   task automatic frame_exp(input logic [23:0] l, input logic [23:0] r, input logic [23:0] el,
                            input logic [23:0] er, input int mode, input int gap);
      l_data_in = l;
      r_data_in = r;
      if (mode == 0) begin
         l_data_en = 1'b1;
         r_data_en = 1'b1;
         lq.push_back('{el, cyc + 2});
         rq.push_back('{er, cyc + 2});
         model_step();
         tick();
         l_data_en = 1'b0;
         r_data_en = 1'b0;
      end else begin
         l_data_en = 1'b1;
         lq.push_back('{el, cyc + 2});
         tick();
         l_data_en = 1'b0;
         r_data_en = 1'b1;
         rq.push_back('{er, cyc + 2});
         model_step();
         tick();
         r_data_en = 1'b0;
      end
      repeat (gap) tick();
   endtask

   task automatic frame(input logic [23:0] l, input logic [23:0] r, input int mode,
                        input int gap);
      frame_exp(l, r, scale(l, g_m), scale(r, g_m), mode, gap);
   endtask

   task automatic l_only(input logic [23:0] l);
      l_data_in = l;
      l_data_en = 1'b1;
      lq.push_back('{scale(l, g_m), cyc + 2});
      tick();
      l_data_en = 1'b0;
   endtask

   task automatic check_quiet(input string name, input int n);
      repeat (n) begin
         tick();
         check({name, "_l_valid"}, {31'd0, l_data_valid}, 32'd0);
         check({name, "_r_valid"}, {31'd0, r_data_valid}, 32'd0);
      end
      check({name, "_l_out"}, {8'd0, l_data_out}, 32'd0);
      check({name, "_r_out"}, {8'd0, r_data_out}, 32'd0);
   endtask

   // Scoreboard: every valid must match the oldest expectation of its channel, on time.
   always @(negedge clk) begin
      while (lq.size() > 0 && lq[0].due < cyc) begin
         n_checks++;
         n_fail++;
         $display("FAIL l_missing: got no valid, expected %h due cycle %0d", lq[0].data,
                  lq[0].due);
         void'(lq.pop_front());
      end
      while (rq.size() > 0 && rq[0].due < cyc) begin
         n_checks++;
         n_fail++;
         $display("FAIL r_missing: got no valid, expected %h due cycle %0d", rq[0].data,
                  rq[0].due);
         void'(rq.pop_front());
      end
      if (l_data_valid) begin
         if (lq.size() == 0) begin
            check("l_unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = lq.pop_front();
            check("l_data", {8'd0, l_data_out}, {8'd0, e.data});
            check("l_latency", cyc, e.due);
         end
      end
      if (r_data_valid) begin
         if (rq.size() == 0) begin
            check("r_unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = rq.pop_front();
            check("r_data", {8'd0, r_data_out}, {8'd0, e.data});
            check("r_latency", cyc, e.due);
         end
      end
   end

   initial begin
      unity_tbl[0] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
      unity_tbl[1] = '{24'h000001, 24'hFFFFFF, 24'h000001, 24'hFFFFFF};
      unity_tbl[2] = '{24'h123456, 24'hEDCBA9, 24'h123456, 24'hEDCBA9};
      unity_tbl[3] = '{24'h000000, 24'h400000, 24'h000000, 24'h400000};
      g64_tbl[0]   = '{24'h100000, 24'h100000, 24'h040000, 24'h040000};
      g64_tbl[1]   = '{24'hF00000, 24'hF00000, 24'hFC0000, 24'hFC0000};
      g64_tbl[2]   = '{24'h000003, 24'hFFFFFD, 24'h000000, 24'hFFFFFF};
      g64_tbl[3]   = '{24'h7FFFFF, 24'h800000, 24'h1FFFFF, 24'hE00000};

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      check("rst_l_valid", {31'd0, l_data_valid}, 32'd0);
      check("rst_r_valid", {31'd0, r_data_valid}, 32'd0);
      check("rst_l_out", {8'd0, l_data_out}, 32'd0);
      check("rst_r_out", {8'd0, r_data_out}, 32'd0);
      check("rst_muted", {31'd0, muted}, 32'd0);
      check("rst_ramping", {31'd0, ramping}, 32'd0);

      // Startup ramp at full volume.
      run = 1'b1;
      g_m = 0;
      repeat (3) tick();
      check("start_ramping", {31'd0, ramping}, 32'd1);
      for (int n = 0; n < 300; n++) begin
         frame(24'h400000, 24'h400000, 1, 2);
         if (n == 254) check("ramp_254_ramping", {31'd0, ramping}, 32'd1);
         if (n == 255) check("ramp_255_ramping", {31'd0, ramping}, 32'd0);
      end

      for (int i = 0; i < 4; i++) begin
         frame_exp(unity_tbl[i].l_in, unity_tbl[i].r_in, unity_tbl[i].exp_l,
                   unity_tbl[i].exp_r, 0, 1);
      end

      // Soft mute from unity down to silence, then unmute.
      mute_req = 1'b1;
      for (int n = 0; n < 256; n++) begin
         frame(24'h400000, 24'h400000, 0, 1);
         if (n == 254) check("mute_254_muted", {31'd0, muted}, 32'd0);
      end
      repeat (2) tick();
      check("mute_done_muted", {31'd0, muted}, 32'd1);
      frame_exp(24'h400000, 24'h400000, 24'h000000, 24'h000000, 0, 1);
      mute_req = 1'b0;
      tick();
      check("unmute_muted", {31'd0, muted}, 32'd0);
      for (int n = 0; n < 258; n++) frame(24'h400000, 24'h400000, 0, 1);

      // Volume 0x80, then 0x40 from hold.
      volume = 8'h80;
      for (int n = 0; n < 130; n++) frame(24'h100000, 24'h100000, 1, 0);
      tick();
      check("vol80_ramping", {31'd0, ramping}, 32'd0);
      volume = 8'h40;
      repeat (2) tick();
      check("vol40_ramping", {31'd0, ramping}, 32'd1);
      for (int n = 0; n < 64; n++) frame(24'h100000, 24'h100000, 0, 1);
      tick();
      check("vol40_hold", {31'd0, ramping}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         frame_exp(g64_tbl[i].l_in, g64_tbl[i].r_in, g64_tbl[i].exp_l, g64_tbl[i].exp_r, 0, 1);
      end

      // Back-to-back strobes while the gain moves every frame.
      volume = 8'h30;
      for (int n = 0; n < 8; n++) frame(24'($urandom()), 24'($urandom()), 0, 0);
      for (int n = 0; n < 4; n++) frame(24'($urandom()), 24'($urandom()), 1, 0);
      l_only(24'h300000);
      l_only(24'hC00000);
      frame(24'h300000, 24'hC00000, 0, 0);
      for (int n = 0; n < 8; n++) frame(24'($urandom()), 24'($urandom()), 0, 1);
      repeat (4) tick();

      // run falls with samples in stage 1.
      volume = 8'hFF;
      l_data_in = 24'h400000;
      r_data_in = 24'h400000;
      l_data_en = 1'b1;
      r_data_en = 1'b1;
      tick();
      l_data_en = 1'b0;
      r_data_en = 1'b0;
      run = 1'b0;
      g_m = 0;
      check_quiet("run_drop", 6);
      check("run_drop_ramping", {31'd0, ramping}, 32'd0);
      run = 1'b1;
      repeat (2) tick();
      for (int n = 0; n < 6; n++) frame(24'h400000, 24'h400000, 0, 1);
      repeat (4) tick();

      // Asynchronous reset with samples in stage 1.
      l_data_en = 1'b1;
      r_data_en = 1'b1;
      tick();
      l_data_en = 1'b0;
      r_data_en = 1'b0;
      reset_n = 1'b0;
      g_m = 0;
      check_quiet("reset_drop", 3);
      reset_n = 1'b1;
      repeat (2) tick();
      for (int n = 0; n < 6; n++) frame(24'h7FFFFF, 24'h800000, 1, 1);

      for (int i = 0; i < 10 && (lq.size() > 0 || rq.size() > 0); i++) tick();
      check("drain_l", lq.size(), 32'd0);
      check("drain_r", rq.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
